// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit type, decade limits and a validity helper
// used by the counter top level and its per-decade sub-module.
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    function automatic logic is_bcd(input bcd_t v);
        return (v <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: clear, parallel load (invalid digits load as 0) and an
// externally enabled up/down step that wraps 9<->0.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic step,
    input  logic up,
    input  logic load,
    input  bcd_t load_d,
    input  logic clr,
    output bcd_t d,
    output logic is_max,
    output logic is_min
);

    assign is_max = (d == BCD_MAX);
    assign is_min = (d == BCD_MIN);

    // NOTE: state registers use non-blocking assignments so every decade
    // samples its neighbours' pre-edge values in the same clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d <= BCD_MIN;
        end else if (clr) begin
            d <= BCD_MIN;
        end else if (load) begin
            d <= is_bcd(load_d) ? load_d : BCD_MIN;
        end else if (step) begin
            if (up) begin
                d <= is_max ? BCD_MIN : d + 4'd1;
            end else begin
                d <= is_min ? BCD_MAX : d - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-decade synchronous BCD up/down counter with terminal count, sticky
// wrap flag and a load-error pulse for non-BCD load digits.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int TC_REG = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in,
    input  logic                      up,
    input  logic                      load,
    input  logic [DIGIT_W*DIGITS-1:0] load_val,
    input  logic                      clr,
    output logic [DIGIT_W*DIGITS-1:0] cnt,
    output logic                      tc,
    output logic                      ovf,
    output logic                      load_err
);

    logic [DIGITS-1:0] is_max;
    logic [DIGITS-1:0] is_min;
    logic [DIGITS-1:0] step;
    logic [DIGITS-1:0] bad_digit;
    logic [DIGITS:0]   chain_max;
    logic [DIGITS:0]   chain_min;
    logic              tc_term;

    // chain_*[k] is true when every lower decade sits at its wrap value, so
    // all decades step together on one edge with no ripple latency.
    assign chain_max[0] = 1'b1;
    assign chain_min[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        assign chain_max[k+1] = chain_max[k] & is_max[k];
        assign chain_min[k+1] = chain_min[k] & is_min[k];
        assign step[k]        = in & (up ? chain_max[k] : chain_min[k]);
        assign bad_digit[k]   = ~is_bcd(load_val[DIGIT_W*k +: DIGIT_W]);

        bcd_digit u_digit (
            .clk    (clk),
            .rst_n  (rst_n),
            .step   (step[k]),
            .up     (up),
            .load   (load),
            .load_d (load_val[DIGIT_W*k +: DIGIT_W]),
            .clr    (clr),
            .d      (cnt[DIGIT_W*k +: DIGIT_W]),
            .is_max (is_max[k]),
            .is_min (is_min[k])
        );
    end

    assign tc_term = in & (up ? chain_max[DIGITS] : chain_min[DIGITS]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end else begin
            load_err <= load & ~clr & (|bad_digit);
            if (clr) begin
                ovf <= 1'b0;
            end else if (!load && tc_term) begin
                ovf <= 1'b1;
            end
        end
    end

    if (TC_REG != 0) begin : g_tc_reg
        logic tc_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tc_q <= 1'b0;
            end else begin
                tc_q <= tc_term;
            end
        end
        assign tc = tc_q;
    end else begin : g_tc_comb
        assign tc = tc_term;
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for a 2-decade BCD counter: one instance with
// combinational tc and one with registered tc share the same stimulus.
module tb_bcd_updown_counter;

    logic       clk;
    logic       rst_n;
    logic       in;
    logic       up;
    logic       load;
    logic       clr;
    logic [7:0] load_val;
    logic [7:0] cnt0, cnt1;
    logic       tc0, tc1;
    logic       ovf0, ovf1;
    logic       lerr0, lerr1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] cnt;
        logic       tc;
        logic       ovf;
        logic       lerr;
    } exp_t;

    exp_t sb[$];

    bcd_updown_counter #(.DIGITS(2), .TC_REG(0)) dut_comb (
        .clk(clk), .rst_n(rst_n), .in(in), .up(up), .load(load),
        .load_val(load_val), .clr(clr), .cnt(cnt0), .tc(tc0),
        .ovf(ovf0), .load_err(lerr0)
    );

    bcd_updown_counter #(.DIGITS(2), .TC_REG(1)) dut_reg (
        .clk(clk), .rst_n(rst_n), .in(in), .up(up), .load(load),
        .load_val(load_val), .clr(clr), .cnt(cnt1), .tc(tc1),
        .ovf(ovf1), .load_err(lerr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Inputs change on the falling edge; the expectation describes tc in the
    // cycle before the next rising edge and the state just after it.
    task automatic drive(input logic c, input logic l, input logic i, input logic u,
                         input logic [7:0] lv, input logic [7:0] e_cnt,
                         input logic e_tc, input logic e_ovf, input logic e_lerr);
        exp_t e;
        @(negedge clk);
        clr = c; load = l; in = i; up = u; load_val = lv;
        e.cnt = e_cnt; e.tc = e_tc; e.ovf = e_ovf; e.lerr = e_lerr;
        sb.push_back(e);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_cnt_comb", cnt0, 8'h00);
        check("rst_cnt_reg", cnt1, 8'h00);
        check("rst_ovf", ovf0, 1'b0);
        check("rst_tc_reg", tc1, 1'b0);
        check("rst_load_err", lerr0, 1'b0);
        #1 rst_n = 1'b1;
        clr = 1'b0; load = 1'b0; in = 1'b0; up = 1'b0;
    endtask

    initial begin : monitor
        exp_t r;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                r = sb.pop_front();
                check("tc_comb", tc0, r.tc);
                @(posedge clk);
                #1;
                check("cnt_comb", cnt0, r.cnt);
                check("ovf_comb", ovf0, r.ovf);
                check("lerr_comb", lerr0, r.lerr);
                check("cnt_reg", cnt1, r.cnt);
                check("tc_reg", tc1, r.tc);
                check("ovf_reg", ovf1, r.ovf);
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0;
        clr = 1'b0; load = 1'b0; in = 1'b0; up = 1'b0; load_val = 8'h00;
        @(negedge clk);
        #1;
        check("init_cnt", cnt0, 8'h00);
        check("init_ovf", ovf0, 1'b0);
        check("init_tc_reg", tc1, 1'b0);
        check("init_lerr", lerr1, 1'b0);
        rst_n = 1'b1;

        // Count up 00..99 and wrap; tc only while cnt=99.
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, 1, 1, 8'h00, to_bcd((i + 1) % 100), i == 99, i == 99, 0);
        end
        drive(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0);

        // Clear, load 10, count down through 00 into 99.
        drive(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        drive(0, 1, 0, 0, 8'h10, 8'h10, 0, 0, 0);
        for (int v = 10; v >= 0; v--) begin
            drive(0, 0, 1, 0, 8'h00, (v == 0) ? 8'h99 : to_bcd(v - 1), v == 0, v == 0, 0);
        end

        // Invalid load digit while counting at 99: load wins, ovf untouched.
        drive(0, 1, 1, 1, 8'h3C, 8'h30, 1, 1, 1);
        drive(0, 0, 0, 1, 8'h00, 8'h30, 0, 1, 0);

        // Load at all-9s with in=1 must not step or set ovf.
        drive(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        drive(0, 1, 0, 0, 8'h99, 8'h99, 0, 0, 0);
        drive(0, 1, 1, 1, 8'h99, 8'h99, 1, 0, 0);
        drive(0, 0, 1, 1, 8'h00, 8'h00, 1, 1, 0);

        // clr beats load and in, and clears ovf.
        drive(0, 1, 0, 0, 8'h47, 8'h47, 0, 1, 0);
        drive(1, 1, 1, 1, 8'h12, 8'h00, 0, 0, 0);
        drive(0, 1, 0, 0, 8'hFA, 8'h00, 0, 0, 1);

        // Hold with in=0 regardless of up.
        drive(0, 1, 0, 0, 8'h58, 8'h58, 0, 0, 0);
        drive(0, 0, 0, 0, 8'h00, 8'h58, 0, 0, 0);
        drive(0, 0, 0, 1, 8'h00, 8'h58, 0, 0, 0);

        // Asynchronous reset between edges, then first step down wraps.
        reset_pulse();
        drive(0, 0, 1, 0, 8'h00, 8'h99, 1, 1, 0);
        reset_pulse();
        drive(0, 0, 1, 1, 8'h00, 8'h01, 0, 0, 0);
        drive(0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 4, number of cascaded BCD decades (1..8).
REQ-002 Parameter TC_REG, default 0; 0 = combinational tc, 1 = tc registered (one cycle later).
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in  input  1  count enable, sampled on rising clk.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 load_val  input  4*DIGITS  BCD load value, digit 0 in bits [3:0].
REQ-009 clr  input  1  synchronous clear of count and ovf.
REQ-010 cnt  output  4*DIGITS  current BCD count, digit 0 in bits [3:0].
REQ-011 tc  output  1  terminal count: next enabled step wraps.
REQ-012 ovf  output  1  sticky wrap (overflow/underflow) flag.
REQ-013 load_err  output  1  one-cycle pulse: load_val held a non-BCD digit.

Function
REQ-014 Each rising clk SHALL apply exactly one action, priority clr > load > in > hold.
REQ-015 clr SHALL set cnt to all zeros and ovf to 0 in the next cycle.
REQ-016 load SHALL copy load_val to cnt; any digit >9 SHALL be loaded as 0 and load_err SHALL pulse high for that one cycle.
REQ-017 in=1, up=1: digit 0 SHALL increment; digit k SHALL increment only when digits 0..k-1 are all 9; any digit at 9 that increments SHALL become 0.
REQ-018 in=1, up=0: digit 0 SHALL decrement; digit k SHALL decrement only when digits 0..k-1 are all 0; any digit at 0 that decrements SHALL become 9.
REQ-019 All digits SHALL update in the same edge (synchronous carry, no ripple latency); cnt latency from in = 1 cycle.
REQ-020 tc (TC_REG=0) SHALL equal in & (up ? all digits 9 : all digits 0), combinationally.
REQ-021 TC_REG=1: tc SHALL be the REQ-020 term registered, asserted one cycle after the qualifying cycle.
REQ-022 Enabled up-step from all-9s SHALL wrap to all-0s and set ovf; enabled down-step from all-0s SHALL wrap to all-9s and set ovf.
REQ-023 ovf SHALL stay 1 until clr or reset; load SHALL NOT affect ovf.
REQ-024 in=0 with no clr/load SHALL hold cnt; up changes while in=0 SHALL have no effect.
REQ-025 Simultaneous clr+load+in: only clr SHALL take effect; load with in=1: loaded value, no count step, no ovf.
REQ-026 cnt SHALL never hold a digit >9 in any reachable state.

Reset
REQ-027 rst_n low SHALL immediately force cnt=0, ovf=0, load_err=0, registered tc=0, independent of clk.
REQ-028 Reset asserted mid-count SHALL discard the in-flight step; first enabled edge after release SHALL move 0 to 1 (up) or 0 to all-9s with ovf=1 (down).
REQ-029 Deassertion SHALL be synchronous-safe: no action on the edge coinciding with rst_n release.

Structure
REQ-030 Shared package bcd_pkg SHALL hold BCD_MAX=9, BCD_MIN=0, digit width constant 4, and the digit typedef.
REQ-031 One sub-module bcd_digit SHALL implement a single decade (inputs step, up, load, load_d, clr; outputs d, is_max, is_min), instantiated DIGITS times by generate.
REQ-032 Carry/borrow enables SHALL be formed in the top level as AND-chains of is_max/is_min.

Verification
REQ-033 DIGITS=2, reset, in=1 up=1 for 100 edges -> cnt steps 00..99 then 00; tc=1 exactly in the cycle cnt=99; ovf=1 from the wrap onward.
REQ-034 DIGITS=2, load 0x10 then in=1 up=0 -> 09, 08; at 00 tc=1, next edge cnt=99, ovf=1.
REQ-035 load_val=0x3C -> cnt=0x30, load_err high one cycle, ovf unchanged.
REQ-036 clr, load, in all high with cnt=0x47 -> cnt=0x00, ovf=0 next cycle.
REQ-037 rst_n pulsed low between edges at cnt=0x58 -> cnt=0x00 immediately, before next clk edge.
REQ-038 TC_REG=1, count up through 99 -> tc high one cycle after cnt=99 is presented, coincident with cnt=00.
